// File: rtl/nes_button_poller.sv
// Periodic NES controller poller with sample debouncing.
// A free-running poll timer issues one-cycle scan requests to a reader stage.
// Each returned sample is compared against the previous one, and the held
// button state only changes once STABLE_POLLS identical samples have been seen.
// Press/release masks and an update strobe accompany every held-state change.
module nes_button_poller #(
  parameter int POLL_CYCLES    = 416666,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STABLE_POLLS   = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  output logic       o_read_buttons,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_update,
  output logic       o_timeout
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int OW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(STABLE_POLLS + 1);

  localparam logic [TW-1:0] TIMER_MAX   = TW'(POLL_CYCLES - 1);
  localparam logic [OW-1:0] TIMEOUT_MAX = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_POLLS);

  typedef enum logic [1:0] {
    WAIT_TICK,
    WAIT_VALID,
    UPDATE
  } state_e;

  state_e        state_q,    state_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic [OW-1:0] tout_q,     tout_d;
  logic [SW-1:0] stable_q,   stable_d;
  logic [7:0]    last_q,     last_d;
  logic [7:0]    sample_q,   sample_d;
  logic [7:0]    buttons_q,  buttons_d;
  logic [7:0]    pressed_q,  pressed_d;
  logic [7:0]    released_q, released_d;
  logic          update_q,   update_d;
  logic          timeout_q,  timeout_d;
  logic          read_q,     read_d;

  logic tick;

  assign tick = i_enable && (timer_q == TIMER_MAX);

  // Next-state and registered-output logic for the poll/debounce sequence.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    timer_d    = i_enable ? ((timer_q == TIMER_MAX) ? '0 : timer_q + TW'(1)) : '0;
    tout_d     = tout_q;
    stable_d   = stable_q;
    last_d     = last_q;
    sample_d   = sample_q;
    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    update_d   = 1'b0;
    timeout_d  = 1'b0;
    read_d     = 1'b0;

    if (!i_enable) begin
      // Abandon any in-flight scan; held state and stable count survive.
      state_d = WAIT_TICK;
    end else begin
      unique case (state_q)
        WAIT_TICK: begin
          if (tick) begin
            read_d  = 1'b1;
            tout_d  = '0;
            state_d = WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          // A strobe on the last allowed cycle still wins over the timeout.
          if (i_valid) begin
            sample_d = i_buttons;
            state_d  = UPDATE;
          end else if (tout_q == TIMEOUT_MAX) begin
            timeout_d = 1'b1;
            stable_d  = '0;
            state_d   = WAIT_TICK;
          end else begin
            tout_d = tout_q + OW'(1);
          end
        end
        UPDATE: begin
          state_d = WAIT_TICK;
          if (sample_q == last_q) begin
            stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
          end else begin
            stable_d = SW'(1);
            last_d   = sample_q;
          end
          if ((stable_d == STABLE_MAX) && (sample_q != buttons_q)) begin
            buttons_d  = sample_q;
            pressed_d  = sample_q & ~buttons_q;
            released_d = ~sample_q & buttons_q;
            update_d   = 1'b1;
          end
        end
        default: state_d = WAIT_TICK;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_TICK;
      timer_q    <= '0;
      tout_q     <= '0;
      stable_q   <= '0;
      last_q     <= '0;
      sample_q   <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      update_q   <= 1'b0;
      timeout_q  <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      timer_q    <= timer_d;
      tout_q     <= tout_d;
      stable_q   <= stable_d;
      last_q     <= last_d;
      sample_q   <= sample_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      update_q   <= update_d;
      timeout_q  <= timeout_d;
      read_q     <= read_d;
    end
  end

  assign o_read_buttons = read_q;
  assign o_buttons      = buttons_q;
  assign o_pressed      = pressed_q;
  assign o_released     = released_q;
  assign o_update       = update_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_nes_button_poller.sv
// Self-checking bench for nes_button_poller: directed scenarios followed by
// randomized scan responses, compared against a behavioural debounce model.
module tb_nes_button_poller;

  localparam int P = 64;
  localparam int T = 32;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rd;
  logic       vld;
  logic [7:0] bin;
  logic [7:0] bout;
  logic [7:0] pr;
  logic [7:0] rl;
  logic       upd;
  logic       tmo;

  always #5 clk = ~clk;

  nes_button_poller #(
    .POLL_CYCLES   (P),
    .TIMEOUT_CYCLES(T),
    .STABLE_POLLS  (S)
  ) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .o_read_buttons(rd),
    .i_valid       (vld),
    .i_buttons     (bin),
    .o_buttons     (bout),
    .o_pressed     (pr),
    .o_released    (rl),
    .o_update      (upd),
    .o_timeout     (tmo)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_read = 0;

  // Behavioural model: last sample, run length of identical samples, held state.
  logic [7:0] m_last;
  int         m_run;
  logic [7:0] m_btn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    m_last = 8'h00;
    m_run  = 0;
    m_btn  = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] s, output logic e_upd,
                              output logic [7:0] e_pr, output logic [7:0] e_rl);
    logic [7:0] old;
    old = m_btn;
    if (s == m_last) m_run = (m_run + 1 > S) ? S : m_run + 1;
    else begin
      m_run  = 1;
      m_last = s;
    end
    e_upd = (m_run == S) && (s != m_btn);
    if (e_upd) begin
      m_btn = s;
      e_pr  = s & ~old;
      e_rl  = ~s & old;
    end else begin
      e_pr = 8'h00;
      e_rl = 8'h00;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd"},  rd,   1'b0);
    check({tag, "_upd"}, upd,  1'b0);
    check({tag, "_tmo"}, tmo,  1'b0);
    check({tag, "_pr"},  pr,   8'h00);
    check({tag, "_rl"},  rl,   8'h00);
    check({tag, "_btn"}, bout, m_btn);
  endtask

  // Advance to the next scan request and check its spacing from the previous one.
  task automatic wait_read(input int exp_gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd && n < 3 * P);
    check("read_gap", cyc - last_read, exp_gap);
    last_read = cyc;
  endtask

  // Answer the request seen this cycle after d cycles with sample s.
  task automatic transact(input logic [7:0] s, input int d);
    logic       e_upd;
    logic [7:0] e_pr;
    logic [7:0] e_rl;
    for (int k = 0; k < d; k++) begin
      tick();
      if (k == 0) check("read_single", rd, 1'b0);
    end
    vld = 1'b1;
    bin = s;
    tick();
    vld = 1'b0;
    bin = 8'($urandom);
    if (d == 0) check("read_single", rd, 1'b0);
    check("upd_early", upd, 1'b0);
    tick();
    model_accept(s, e_upd, e_pr, e_rl);
    check("upd",      upd,  e_upd);
    check("buttons",  bout, m_btn);
    check("pressed",  pr,   e_pr);
    check("released", rl,   e_rl);
    check("tmo_none", tmo,  1'b0);
    tick();
    check("upd_after", upd, 1'b0);
    check("pr_after",  pr,  8'h00);
    check("rl_after",  rl,  8'h00);
  endtask

  // Leave the request unanswered and expect the timeout strobe.
  task automatic no_answer();
    logic [7:0] held;
    held = m_btn;
    for (int k = 1; k <= T + 1; k++) begin
      tick();
      if (k == 1) check("read_single", rd, 1'b0);
      if (k == T - 1) check("tmo_early", tmo, 1'b0);
      if (k == T) begin
        check("tmo", tmo, 1'b1);
        check("tmo_btn", bout, held);
        check("tmo_upd", upd, 1'b0);
      end
      if (k == T + 1) check("tmo_after", tmo, 1'b0);
    end
    m_run = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vld   = 1'b0;
    bin   = 8'h00;
    model_reset();
    #12;
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_idle_outputs("disabled");

    // Polling cadence after enable.
    en = 1'b1;
    last_read = cyc;
    wait_read(P);
    transact(8'h01, 0);            // first 0x01: no update
    wait_read(P);
    transact(8'h01, 3);            // second 0x01: accepted
    wait_read(P);
    transact(8'h81, 1);
    wait_read(P);
    transact(8'h80, 5);
    wait_read(P);
    transact(8'h80, 2);            // 0x01 -> 0x80
    wait_read(P);
    no_answer();
    wait_read(P);
    transact(8'h80, 0);            // run restarted by timeout: no update
    wait_read(P);
    transact(8'h02, 4);
    wait_read(P);
    transact(8'h02, T - 1);        // valid on the timeout cycle wins
    wait_read(P);

    // Randomized responses.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] s;
      s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_last;
      if ($urandom_range(0, 7) == 0) no_answer();
      else transact(s, $urandom_range(0, T - 1));
      wait_read(P);
    end

    // Enable drop mid-transaction: late strobe ignored, state held.
    tick();
    en = 1'b0;
    tick();
    tick();
    vld = 1'b1;
    bin = 8'hFF;
    tick();
    vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_idle_outputs("en_drop");
    end
    en = 1'b1;
    last_read = cyc;
    wait_read(P);
    transact(m_last, 2);
    wait_read(P);

    // Reset in WAIT_VALID discards the transaction.
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("mid_reset");
    tick();
    vld = 1'b1;
    bin = 8'hFF;
    tick();
    vld = 1'b0;
    rst_n = 1'b1;
    last_read = cyc;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle_outputs("post_reset");
    end
    wait_read(P);
    transact(8'h44, 1);
    wait_read(P);
    transact(8'h44, 6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
